sram_ctrl: RTL and testbench

Parametrised controller for the external asynchronous SRAM (1M x 8 on the Upduino board). It sits between on-chip logic and the SRAM pins. It turns a single-cycle request handshake into correctly sequenced CE/OE/WE strobes, with a configurable number of wait cycles. It optionally keeps the board heartbeat LED that the original SRAM blinky provided.

---
 rtl/sram_ctrl.sv | 167 ++++++++++++++++
 tb/tb_sram_ctrl.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/sram_ctrl.sv
// sram_ctrl: request/handshake controller for an external asynchronous SRAM.
// A single-cycle request (i_req while o_ready) is turned into registered
// CE/OE/WE strobes that are held for WAIT_CYCLES+1 clocks. An END cycle follows,
// then the controller returns to IDLE.
// Optional feature macro: SRAM_LED_EN. When it is defined, o_led is a heartbeat
// LED (free-running counter MSB XOR an access-activity toggle). When it is
// undefined, o_led is tied to 0.
//
// Handshake: a request is accepted on a rising edge where o_ready=1 and
// i_req=1. i_req in any other cycle is ignored. o_rvalid is a one-cycle pulse
// in the END cycle of a read, and o_rdata holds its value until the next read
// completes.
module sram_ctrl #(
    parameter int ADDR_BITS   = 20,
    parameter int DATA_BITS   = 8,
    parameter int WAIT_CYCLES = 1,
    parameter int CBITS       = 26
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic                 i_req,
    input  logic                 i_we,
    input  logic [ADDR_BITS-1:0] i_addr,
    input  logic [DATA_BITS-1:0] i_wdata,
    output logic                 o_ready,
    output logic                 o_rvalid,
    output logic [DATA_BITS-1:0] o_rdata,
    output logic [ADDR_BITS-1:0] o_sram_addr,
    inout  wire  [DATA_BITS-1:0] io_sram_data,
    output logic                 o_sram_ce_n,
    output logic                 o_sram_oe_n,
    output logic                 o_sram_we_n,
    output logic                 o_led
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_END    = 2'd2
    } state_t;

    localparam logic [3:0] WAIT_LAST = 4'(WAIT_CYCLES);

    // Catch parameter values that are out of range at elaboration time.
    if (WAIT_CYCLES < 0 || WAIT_CYCLES > 15 || CBITS < 1) begin : g_param_check
        $error("sram_ctrl: WAIT_CYCLES must be 0..15 and CBITS must be >= 1");
    end

    // The current state is kept in a named signal so checkers can observe it.
    state_t                 state;
    state_t                 state_next;
    logic   [3:0]           wait_cnt;
    logic   [3:0]           wait_cnt_next;
    logic                   we_q;
    logic                   we_next;
    logic   [DATA_BITS-1:0] wdata_q;
    logic                   drive_q;
    logic                   accept;

    logic                   ce_n_next;
    logic                   oe_n_next;
    logic                   we_n_next;
    logic                   drive_next;
    logic                   rvalid_next;
    logic                   capture;

    assign accept  = (state == S_IDLE) && i_req;
    assign capture = (state == S_ACCESS) && (wait_cnt == WAIT_LAST) && !we_q;

    // Next-state logic, plus next values of the registered strobes.
    // The strobes are decoded from the next state, so the pins come straight
    // from flops and cannot glitch.
    always_comb begin
        state_next    = state;
        wait_cnt_next = wait_cnt;
        we_next       = we_q;
        case (state)
            S_IDLE: begin
                if (i_req) begin
                    state_next    = S_ACCESS;
                    wait_cnt_next = 4'd0;
                    we_next       = i_we;
                end
            end
            S_ACCESS: begin
                if (wait_cnt == WAIT_LAST) begin
                    state_next = S_END;
                end else begin
                    wait_cnt_next = wait_cnt + 4'd1;
                end
            end
            S_END: begin
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
        ce_n_next   = (state_next != S_ACCESS);
        oe_n_next   = !((state_next == S_ACCESS) && !we_next);
        we_n_next   = !((state_next == S_ACCESS) && we_next);
        // The write bus stays driven through END, which gives the SRAM data hold time.
        drive_next  = we_next && ((state_next == S_ACCESS) || (state_next == S_END));
        rvalid_next = (state_next == S_END) && !we_next;
    end

    // State, latched request fields, registered strobes and read capture.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state       <= S_IDLE;
            wait_cnt    <= 4'd0;
            we_q        <= 1'b0;
            wdata_q     <= '0;
            drive_q     <= 1'b0;
            o_sram_addr <= '0;
            o_sram_ce_n <= 1'b1;
            o_sram_oe_n <= 1'b1;
            o_sram_we_n <= 1'b1;
            o_ready     <= 1'b1;
            o_rvalid    <= 1'b0;
            o_rdata     <= '0;
        end else begin
            state       <= state_next;
            wait_cnt    <= wait_cnt_next;
            we_q        <= we_next;
            drive_q     <= drive_next;
            o_sram_ce_n <= ce_n_next;
            o_sram_oe_n <= oe_n_next;
            o_sram_we_n <= we_n_next;
            o_ready     <= (state_next == S_IDLE);
            o_rvalid    <= rvalid_next;
            if (accept) begin
                o_sram_addr <= i_addr;
                wdata_q     <= i_wdata;
            end
            if (capture) begin
                o_rdata <= io_sram_data;
            end
        end
    end

    // The data pins are driven only from the latched write register.
    assign io_sram_data = drive_q ? wdata_q : {DATA_BITS{1'bz}};

`ifdef SRAM_LED_EN
    logic [CBITS-1:0] led_cnt;
    logic             led_toggle;

    // Free-running heartbeat counter; each completed access flips the activity toggle.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            led_cnt    <= '0;
            led_toggle <= 1'b0;
        end else begin
            led_cnt <= led_cnt + 1'b1;
            if (state == S_END) begin
                led_toggle <= ~led_toggle;
            end
        end
    end

    assign o_led = led_cnt[CBITS-1] ^ led_toggle;
`else
    assign o_led = 1'b0;
`endif

endmodule

// File: tb/tb_sram_ctrl.sv
// tb_sram_ctrl: randomized, scoreboard-checked bench for sram_ctrl
// (WAIT_CYCLES=2, CBITS=4). It includes a behavioural asynchronous SRAM and a
// reference memory that is indexed by address.
module tb_sram_ctrl;

  localparam int AW = 20;
  localparam int DW = 8;
  localparam int W  = 2;
  localparam int CB = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          i_reset = 1'b1;
  logic          i_req = 1'b0;
  logic          i_we = 1'b0;
  logic [AW-1:0] i_addr = '0;
  logic [DW-1:0] i_wdata = '0;
  logic          o_ready, o_rvalid, o_led;
  logic [DW-1:0] o_rdata;
  logic [AW-1:0] o_sram_addr;
  wire  [DW-1:0] io_sram_data;
  logic          ce_n, oe_n, we_n;

  sram_ctrl #(.ADDR_BITS(AW), .DATA_BITS(DW), .WAIT_CYCLES(W), .CBITS(CB)) dut (
    .i_clk(clk), .i_reset(i_reset), .i_req(i_req), .i_we(i_we),
    .i_addr(i_addr), .i_wdata(i_wdata), .o_ready(o_ready), .o_rvalid(o_rvalid),
    .o_rdata(o_rdata), .o_sram_addr(o_sram_addr), .io_sram_data(io_sram_data),
    .o_sram_ce_n(ce_n), .o_sram_oe_n(oe_n), .o_sram_we_n(we_n), .o_led(o_led)
  );

  // ---------------- behavioural SRAM ----------------
  logic [DW-1:0] mem [int];
  logic [DW-1:0] sram_q = '0;
  assign io_sram_data = (!ce_n && !oe_n && we_n) ? sram_q : {DW{1'bz}};

  always @(negedge clk) begin
    if (!ce_n && !we_n) mem[int'(o_sram_addr)] = io_sram_data;
    sram_q = mem.exists(int'(o_sram_addr)) ? mem[int'(o_sram_addr)] : '0;
  end

  // ---------------- reference model / scoreboard ----------------
  logic [DW-1:0] ref_mem [int];
  logic [DW-1:0] exp_q [$];
  int checks = 0;
  int failures = 0;
  int cyc = 0;   // rising edges since the last reset edge
  int ends = 0;  // accesses completed since the last reset
  logic [DW-1:0] zz = 8'hzz;

  always @(posedge clk) begin
    if (i_reset) cyc <= 0;
    else cyc <= cyc + 1;
  end

  function automatic logic [DW-1:0] ref_read(input logic [AW-1:0] a);
    return ref_mem.exists(int'(a)) ? ref_mem[int'(a)] : '0;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%h expected=%h at t=%0t", name, got, exp, $time);
    end
  endtask

  task automatic chk_led();
`ifdef SRAM_LED_EN
    chk("led", {31'b0, o_led}, {31'b0, 1'(((cyc >> 3) & 1) ^ (ends & 1))});
`else
    chk("led_off", {31'b0, o_led}, 32'd0);
`endif
  endtask

  // Monitor: every o_rvalid pulse pops one expected read value.
  always @(negedge clk) begin
    if (o_rvalid === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_rvalid", 32'd1, 32'd0);
      end else begin
        chk("rdata", {24'b0, o_rdata}, {24'b0, exp_q.pop_front()});
      end
    end
  end

  // ---------------- driver tasks (called at a negedge) ----------------
  task automatic wait_ready(output bit ok);
    ok = 1'b0;
    for (int t = 0; t < 50; t++) begin
      if (o_ready === 1'b1) begin
        ok = 1'b1;
        return;
      end
      @(negedge clk);
    end
    chk("ready_timeout", 32'd0, 32'd1);
  endtask

  task automatic do_access(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    bit ok;
    wait_ready(ok);
    if (!ok) return;
    chk_led();
    i_req = 1'b1; i_we = we; i_addr = a; i_wdata = d;
    if (we) ref_mem[int'(a)] = d;
    else exp_q.push_back(ref_read(a));
    @(posedge clk);  // acceptance edge 0
    for (int k = 1; k <= W + 3; k++) begin
      @(negedge clk);
      if (k <= W + 1) begin
        chk("acc_ce", {31'b0, ce_n}, 32'd0);
        chk("acc_oe", {31'b0, oe_n}, {31'b0, we});
        chk("acc_we", {31'b0, we_n}, {31'b0, !we});
        chk("acc_addr", {12'b0, o_sram_addr}, {12'b0, a});
        chk("acc_ready", {31'b0, o_ready}, 32'd0);
        if (we) chk("acc_bus", {24'b0, io_sram_data}, {24'b0, d});
      end else if (k == W + 2) begin
        chk("end_strobes", {29'b0, ce_n, oe_n, we_n}, 32'd7);
        chk("end_bus", {24'b0, io_sram_data}, {24'b0, (we ? d : zz)});
        chk("end_rvalid", {31'b0, o_rvalid}, {31'b0, !we});
        chk("end_ready", {31'b0, o_ready}, 32'd0);
        chk("end_addr", {12'b0, o_sram_addr}, {12'b0, a});
      end else begin
        chk("idle_ready", {31'b0, o_ready}, 32'd1);
        chk("idle_bus", {24'b0, io_sram_data}, {24'b0, zz});
        chk("idle_strobes", {29'b0, ce_n, oe_n, we_n}, 32'd7);
      end
      // Input changes after acceptance must not matter; requests while busy are dropped.
      if (k <= W + 1) begin
        i_req = 1'($urandom_range(0, 1)); i_we = 1'($urandom_range(0, 1));
        i_addr = AW'($urandom); i_wdata = DW'($urandom);
      end else begin
        i_req = 1'b0;
      end
    end
    ends++;
  endtask

  task automatic idle_window(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      chk_led();
      chk("idle_ready_w", {31'b0, o_ready}, 32'd1);
    end
  endtask

  // ---------------- main stimulus ----------------
  initial begin : main
    logic [AW-1:0] pool [4];
    logic [AW-1:0] cur;
    int acc;
    bit ok;
    pool[0] = 20'h12345; pool[1] = 20'h00000; pool[2] = 20'hFFFFF; pool[3] = 20'h0ABCD;

    // Reset held with a pending request: the request is dropped.
    i_reset = 1'b1; i_req = 1'b1; i_we = 1'b1; i_addr = 20'h00055; i_wdata = 8'h3C;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst_ready", {31'b0, o_ready}, 32'd1);
      chk("rst_strobes", {29'b0, ce_n, oe_n, we_n}, 32'd7);
      chk("rst_bus", {24'b0, io_sram_data}, {24'b0, zz});
      chk("rst_rvalid", {31'b0, o_rvalid}, 32'd0);
      chk("rst_rdata", {24'b0, o_rdata}, 32'd0);
      chk("rst_addr", {12'b0, o_sram_addr}, 32'd0);
      chk("rst_led", {31'b0, o_led}, 32'd0);
    end
    i_reset = 1'b0; i_req = 1'b0; ends = 0;

    // Heartbeat with no traffic.
    idle_window(20);

    // Directed write, then a read back of the same location.
    do_access(1'b1, 20'h12345, 8'hA5);
    idle_window(10);
    do_access(1'b0, 20'h12345, 8'h00);
    @(negedge clk);
    chk("rdata_held", {24'b0, o_rdata}, 32'h0A5);

    // Reset asserted during cycle 2 of a read aborts it.
    wait_ready(ok);
    i_req = 1'b1; i_we = 1'b0; i_addr = 20'h12345;
    @(posedge clk);
    @(negedge clk); i_req = 1'b0;  // cycle 1
    @(negedge clk); i_reset = 1'b1; i_req = 1'b1;  // cycle 2
    @(negedge clk);
    chk("abort_strobes", {29'b0, ce_n, oe_n, we_n}, 32'd7);
    chk("abort_bus", {24'b0, io_sram_data}, {24'b0, zz});
    chk("abort_rvalid", {31'b0, o_rvalid}, 32'd0);
    chk("abort_rdata", {24'b0, o_rdata}, 32'd0);
    chk("abort_ready", {31'b0, o_ready}, 32'd1);
    i_reset = 1'b0; i_req = 1'b0; ends = 0;
    idle_window(6);

    // Prime both extreme addresses, then hold i_req high continuously.
    do_access(1'b1, 20'h00000, 8'h5A);
    do_access(1'b1, 20'hFFFFF, 8'hC3);
    acc = 0; cur = '0;
    i_req = 1'b1; i_we = 1'b0;
    for (int n = 0; n <= 20; n++) begin
      chk("b2b_ready", {31'b0, o_ready}, {31'b0, (n % (W + 3)) == 0});
      if (n > 0 && (n % (W + 3)) != 0 && (n % (W + 3)) <= W + 1)
        chk("b2b_addr", {12'b0, o_sram_addr}, {12'b0, cur});
      if (o_ready === 1'b1 && n < 20) begin
        cur = (acc % 2 == 0) ? 20'h00000 : 20'hFFFFF;
        i_addr = cur;
        exp_q.push_back(ref_read(cur));
        acc++;
      end
      if (n == 20) i_req = 1'b0;
      @(negedge clk);
    end
    ends += acc;

    // Randomized traffic against the reference memory.
    for (int t = 0; t < 24; t++) begin
      logic [AW-1:0] a;
      a = ($urandom_range(0, 3) == 0) ? AW'($urandom) : pool[$urandom_range(0, 3)];
      do_access(1'($urandom_range(0, 1)), a, DW'($urandom));
    end
    idle_window(18);

    // Drain and report.
    repeat (8) @(negedge clk);
    chk("scoreboard_empty", exp_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish within the time limit");
    $fatal(1, "watchdog");
  end

endmodule
